ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle instruction sequencer for the nibble CPU. It fetches each 8-bit instruction over a req/ack memory port and holds it in an instruction register that drives the decoder. It then steps the instruction through decode, execute, optional data-memory access and write-back, producing one-cycle strobes for the ALU and register file. It owns the 16-bit program counter and applies jumps when the decoder reports a taken branch.

## Interface
Parameters:
- PC_RESET, 16'h0000, program counter value loaded on reset
- PC_W, 16, program counter width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = keep issuing instructions; 0 = stop at next instruction boundary
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction memory acknowledge; imem_data valid when high
- imem_data  in  8  fetched instruction byte
- pc  out  PC_W  address of instruction being fetched/executed
- instr  out  8  instruction register, feeds decoder
- dec_fetch  in  1  decoder: instruction is load/store
- dec_we  in  1  decoder: instruction is store
- dec_arith  in  1  decoder: instruction is an ALU op (opcode arithmetic bit == 0)
- dec_jmp  in  1  decoder: instruction is JMP or JPL
- dec_branch  in  1  decoder: condition satisfied
- pc_target  in  PC_W  jump destination from 16-bit register file
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable, valid with dmem_req
- dmem_ack  in  1  data memory acknowledge
- alu_clk  out  1  one-cycle ALU strobe
- reg_we  out  1  one-cycle register-file write strobe
- busy  out  1  high in every state except IDLE
- icount  out  16  retired-instruction counter
- state  out  3  current state encoding, debug

## Operation
- States, with encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 are illegal and return to IDLE on the next edge.
- IDLE:
  - All strobes low.
  - When run=1, go to FETCH.
- FETCH:
  - imem_req=1.
  - On an edge with imem_ack=1: load imem_data into instr and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Single cycle; the decoder settles on the new instr.
  - Always go to EXEC.
- EXEC:
  - alu_clk=1 for this cycle only if dec_arith=1.
  - If dec_fetch=1, go to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_we.
  - On an edge with dmem_ack=1, go to WB; otherwise stay in MEM.
- WB:
  - reg_we=1 unless dec_we=1 (stores do not write registers).
  - pc update: if dec_jmp && dec_branch, pc <= pc_target; otherwise pc <= pc+1, wrapping 16'hFFFF to 16'h0000.
  - icount <= icount+1, wrapping.
  - Go to FETCH if run=1, otherwise IDLE.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction completes that instruction.
- instr changes only on the FETCH ack edge and is otherwise stable.
- Acks received outside their own request state (imem_ack outside FETCH, dmem_ack outside MEM) are ignored.
- Decoder inputs are sampled only in the states that use them.

## Timing
- Reset (asynchronous, immediate):
  - pc=PC_RESET, instr=8'h00, icount=0, state=IDLE.
  - imem_req, dmem_req, dmem_we, alu_clk, reg_we and busy are all 0.
- Request handshake:
  - A request is driven from state registers. It rises on the edge entering its state and stays high until the edge on which its ack is sampled high.
  - The request drops the cycle after the ack. Zero-wait memory (ack tied high) therefore gives one-cycle requests.
- Instruction latency, with zero-wait memories, from FETCH entry to next FETCH entry:
  - 4 cycles for non-memory instructions.
  - 5 cycles for load/store.
  - Each memory wait cycle adds 1.
- alu_clk and reg_we are each high for exactly one cycle per instruction at most.
- Deasserting rst_n mid-request drops the request immediately. A late ack after reset is ignored.
- A jump to the current pc is legal: pc is reloaded with the same value and the instruction is refetched.

## Test plan
- Reset, then run=1, zero-wait memories, program of 3 ALU ops:
  - imem_req pulses at cycles 1, 5 and 9.
  - alu_clk high once per instruction.
  - pc steps 0→1→2→3.
  - icount=3.
- Store with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles with dmem_we=1.
  - reg_we stays 0.
  - Total instruction time 8 cycles.
- JMP with dec_branch=1, pc_target=16'h1234: next imem_req issued with pc=16'h1234.
- JMP with dec_branch=0: pc advances to pc+1.
- Wrap-around: pc preset by jump to 16'hFFFF, then a non-jump retires → pc=16'h0000.
- Stop and reset behaviour:
  - run dropped during MEM: the instruction completes and the sequencer goes to IDLE with busy=0.
  - rst_n pulsed low during FETCH: imem_req drops in the same cycle, pc=PC_RESET, and an ack on the following cycle is ignored.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// Bundle of sequencer-side signals: instruction/data memory ports, decoder
// hooks, strobes and status. The sequencer is the master.
interface ctrl_seq_if #(
    parameter int PC_W = 16
);
    logic            run;
    logic            imem_req;
    logic            imem_ack;
    logic [7:0]      imem_data;
    logic [PC_W-1:0] pc;
    logic [7:0]      instr;
    logic            dec_fetch;
    logic            dec_we;
    logic            dec_arith;
    logic            dec_jmp;
    logic            dec_branch;
    logic [PC_W-1:0] pc_target;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            alu_clk;
    logic            reg_we;
    logic            busy;
    logic [15:0]     icount;
    logic [2:0]      state;

    modport master (
        input  run, imem_ack, imem_data,
        input  dec_fetch, dec_we, dec_arith, dec_jmp, dec_branch, pc_target,
        input  dmem_ack,
        output imem_req, pc, instr, dmem_req, dmem_we,
        output alu_clk, reg_we, busy, icount, state
    );

    modport slave (
        output run, imem_ack, imem_data,
        output dec_fetch, dec_we, dec_arith, dec_jmp, dec_branch, pc_target,
        output dmem_ack,
        input  imem_req, pc, instr, dmem_req, dmem_we,
        input  alu_clk, reg_we, busy, icount, state
    );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// memory access and write-back, with program counter and retire counter.
module ctrl_seq #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] PC_RESET = '0
) (
    input logic        clk,
    input logic        rst_n,
    ctrl_seq_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]      state_q,  state_d;
    logic [PC_W-1:0] pc_q,     pc_d;
    logic [7:0]      instr_q,  instr_d;
    logic [15:0]     icount_q, icount_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        icount_d = icount_q;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = bus.dec_fetch ? S_MEM : S_WB;
            S_MEM:    if (bus.dmem_ack) state_d = S_WB;
            S_WB: begin
                pc_d     = (bus.dec_jmp && bus.dec_branch) ? bus.pc_target : pc_q + PC_ONE;
                icount_d = icount_q + 16'd1;
                state_d  = bus.run ? S_FETCH : S_IDLE;
            end
            // Codes 6 and 7 are unreachable in normal operation; recover to IDLE.
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RESET;
            instr_q  <= 8'h00;
            icount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            icount_q <= icount_d;
        end
    end

    // Requests and strobes decode straight from the state register so that
    // an asynchronous reset drops them immediately.
    assign bus.imem_req = (state_q == S_FETCH);
    assign bus.dmem_req = (state_q == S_MEM);
    assign bus.dmem_we  = (state_q == S_MEM) && bus.dec_we;
    assign bus.alu_clk  = (state_q == S_EXEC) && bus.dec_arith;
    assign bus.reg_we   = (state_q == S_WB) && !bus.dec_we;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.pc       = pc_q;
    assign bus.instr    = instr_q;
    assign bus.icount   = icount_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: acts as memories and a toy decoder, checks each
// instruction's cycle count, strobes and pc/icount against a transaction model.
module tb_ctrl_seq;
    localparam logic [15:0] PC_RST = 16'h0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ctrl_seq_if #(.PC_W(16)) bus ();

    ctrl_seq #(.PC_W(16), .PC_RESET(PC_RST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Toy decoder: bit7 = memory op, bit6 = store, bit5 = non-ALU,
    // bit4 = jump (non-memory only), bit3 = condition true.
    assign bus.dec_fetch  = bus.instr[7];
    assign bus.dec_we     = bus.instr[7] & bus.instr[6];
    assign bus.dec_arith  = ~bus.instr[5] & ~bus.instr[7];
    assign bus.dec_jmp    = bus.instr[4] & ~bus.instr[7];
    assign bus.dec_branch = bus.instr[3];

    int          errors   = 0;
    int          checks   = 0;
    int          cycle_no = 0;
    int          n_instr  = 0;
    logic [15:0] exp_pc;
    logic [15:0] exp_icount;
    bit          exp_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cycle_no++;
    endtask

    // Runs one instruction starting from the FETCH cycle. iw/dw are wait
    // cycles on imem/dmem; mid_run 0/1 fixes run mid-instruction, 2 randomizes.
    task automatic do_instr(input logic [7:0] op, input int iw, input int dw,
                            input logic [15:0] tgt, input int mid_run,
                            input bit run_next, output int start);
        bit f    = op[7];
        bit we   = op[7] & op[6];
        bit ar   = !op[5] && !op[7];
        bit jp   = op[4] && !op[7];
        bit br   = op[3];
        int ncyc = 4 + iw + (f ? dw + 1 : 0);
        int mlo  = iw + 3;
        int mack = iw + 3 + dw;
        int ireq_n = 0, dreq_n = 0, dwe_n = 0, busy_n = 0;
        int alu_n = 0, alu_at = -1, rwe_n = 0, rwe_at = -1;

        if (exp_idle) begin
            bus.run = 1'b1;
            step();
        end
        start = cycle_no;
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_pc", 32'(bus.pc), 32'(exp_pc));
        bus.pc_target = tgt;

        for (int c = 0; c < ncyc; c++) begin
            if (bus.imem_req) ireq_n++;
            if (bus.dmem_req) dreq_n++;
            if (bus.dmem_req && bus.dmem_we) dwe_n++;
            if (bus.busy) busy_n++;
            if (bus.alu_clk) begin alu_n++; alu_at = c; end
            if (bus.reg_we) begin rwe_n++; rwe_at = c; end

            bus.imem_data = (c == iw) ? op : 8'($urandom);
            if (c < iw)       bus.imem_ack = 1'b0;
            else if (c == iw) bus.imem_ack = 1'b1;
            else              bus.imem_ack = 1'($urandom_range(0, 1));
            if (f && c >= mlo && c <= mack) bus.dmem_ack = (c == mack);
            else                            bus.dmem_ack = 1'($urandom_range(0, 1));
            if (c == ncyc - 1)    bus.run = run_next;
            else if (mid_run == 2) bus.run = 1'($urandom_range(0, 1));
            else                   bus.run = (mid_run != 0);
            step();
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        exp_pc     = (jp && br) ? tgt : exp_pc + 16'd1;
        exp_icount = exp_icount + 16'd1;
        exp_idle   = !run_next;
        n_instr++;

        chk("imem_req_cycles", 32'(ireq_n), 32'(iw + 1));
        chk("dmem_req_cycles", 32'(dreq_n), f ? 32'(dw + 1) : 32'd0);
        chk("dmem_we_cycles", 32'(dwe_n), we ? 32'(dw + 1) : 32'd0);
        chk("busy_cycles", 32'(busy_n), 32'(ncyc));
        chk("alu_count", 32'(alu_n), ar ? 32'd1 : 32'd0);
        chk("alu_cycle", 32'(alu_at), ar ? 32'(iw + 2) : 32'hFFFF_FFFF);
        chk("regwe_count", 32'(rwe_n), we ? 32'd0 : 32'd1);
        chk("regwe_cycle", 32'(rwe_at), we ? 32'hFFFF_FFFF : 32'(ncyc - 1));
        chk("end_state", 32'(bus.state), run_next ? 32'd1 : 32'd0);
        chk("end_busy", 32'(bus.busy), run_next ? 32'd1 : 32'd0);
        chk("end_pc", 32'(bus.pc), 32'(exp_pc));
        chk("end_icount", 32'(bus.icount), 32'(exp_icount));
        chk("instr_reg", 32'(bus.instr), 32'(op));
        $display("instr %0d op=%02h iw=%0d dw=%0d start=%0d cycles=%0d pc->%04h icount=%0d",
                 n_instr, op, iw, dw, start, ncyc, exp_pc, exp_icount);
    endtask

    task automatic rand_instr(output int start);
        do_instr(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                 16'($urandom), 2, ($urandom_range(0, 3) != 0), start);
    endtask

    initial begin
        int s;
        bus.run       = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;
        bus.dmem_ack  = 1'b0;
        bus.pc_target = 16'h0000;

        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(bus.pc), 32'(PC_RST));
        chk("rst_instr", 32'(bus.instr), 32'h0);
        chk("rst_icount", 32'(bus.icount), 32'h0);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_strobes", {26'h0, bus.imem_req, bus.dmem_req, bus.dmem_we,
                            bus.alu_clk, bus.reg_we, bus.busy}, 32'h0);

        rst_n      = 1'b1;
        cycle_no   = 0;
        exp_pc     = PC_RST;
        exp_icount = 16'd0;
        exp_idle   = 1'b1;
        chk("idle_after_rst", 32'(bus.state), 32'd0);

        // Three ALU ops, zero-wait memories: fetches begin at cycles 1, 5, 9.
        do_instr(8'h00, 0, 0, 16'h0, 1, 1'b1, s);
        chk("fetch_cycle_a", 32'(s), 32'd1);
        do_instr(8'h01, 0, 0, 16'h0, 1, 1'b1, s);
        chk("fetch_cycle_b", 32'(s), 32'd5);
        do_instr(8'h02, 0, 0, 16'h0, 1, 1'b1, s);
        chk("fetch_cycle_c", 32'(s), 32'd9);
        chk("pc_after_three", 32'(bus.pc), 32'h3);
        chk("icount_three", 32'(bus.icount), 32'd3);

        // Store with three dmem wait cycles: 8-cycle instruction.
        do_instr(8'hC0, 0, 3, 16'h0, 1, 1'b1, s);
        chk("store_len", 32'(cycle_no - s), 32'd8);

        // Taken and not-taken jumps.
        do_instr(8'h38, 0, 0, 16'h1234, 1, 1'b1, s);
        chk("jmp_taken_pc", 32'(bus.pc), 32'h1234);
        do_instr(8'h30, 1, 0, 16'hBEEF, 1, 1'b1, s);
        chk("jmp_not_taken_pc", 32'(bus.pc), 32'h1235);

        // Wrap-around from FFFF, then jump to self.
        do_instr(8'h38, 0, 0, 16'hFFFF, 1, 1'b1, s);
        do_instr(8'h00, 0, 0, 16'h0, 1, 1'b1, s);
        chk("pc_wrap", 32'(bus.pc), 32'h0);
        do_instr(8'h38, 0, 0, exp_pc, 1, 1'b1, s);
        chk("jmp_self", 32'(bus.pc), 32'h0);

        // Load with run low throughout: completes and stops in IDLE.
        do_instr(8'h80, 0, 2, 16'h0, 0, 1'b0, s);
        step();
        chk("stay_idle", 32'(bus.state), 32'd0);

        for (int i = 0; i < 40; i++) rand_instr(s);

        // Reset pulse during FETCH; a late ack afterwards must be ignored.
        if (exp_idle) begin
            bus.run = 1'b1;
            step();
        end
        chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_drop", 32'(bus.imem_req), 32'd0);
        chk("rst_pc_async", 32'(bus.pc), 32'(PC_RST));
        chk("rst_state_async", 32'(bus.state), 32'd0);
        chk("rst_icount_async", 32'(bus.icount), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.run       = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hA5;
        step();
        bus.imem_ack  = 1'b0;
        chk("late_ack_state", 32'(bus.state), 32'd0);
        chk("late_ack_instr", 32'(bus.instr), 32'h0);
        chk("late_ack_req", 32'(bus.imem_req), 32'd0);
        exp_pc     = PC_RST;
        exp_icount = 16'd0;
        exp_idle   = 1'b1;

        for (int i = 0; i < 10; i++) rand_instr(s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
